mcu_bus_transmitter: RTL

Drives the 8-bit parallel MCU bus, meaning the bus clock, the 8 data lines and the command/data select, from the system clock domain. It is the sending end of the protocol that `mcu_bus` receives. Bytes are queued, each tagged as command or data, and serialized one per bus clock. The receiver samples on the rising edge of the bus clock. The block serves as the MCU-side model in system benches and as the driver for board-to-board GPU links.

---
 rtl/mcu_bus_transmitter_if.sv | 40 ++++
 rtl/mcu_bus_transmitter.sv | 119 +++++++++++
 2 files changed

// File: rtl/mcu_bus_transmitter_if.sv
// MCU parallel bus transmitter: write port, status flags and bus pins.
// master writes bytes; slave is the transmitter driving the bus.
interface mcu_bus_transmitter_if;
  logic       write_enable;
  logic [7:0] write_byte;
  logic       write_is_data;
  logic       fifo_full;
  logic       fifo_empty;
  logic       busy;
  logic       overflow;
  logic       mcu_bus_clock;
  logic [7:0] mcu_bus;
  logic       mcu_bus_command_data;

  modport master (
    output write_enable,
    output write_byte,
    output write_is_data,
    input  fifo_full,
    input  fifo_empty,
    input  busy,
    input  overflow,
    input  mcu_bus_clock,
    input  mcu_bus,
    input  mcu_bus_command_data
  );

  modport slave (
    input  write_enable,
    input  write_byte,
    input  write_is_data,
    output fifo_full,
    output fifo_empty,
    output busy,
    output overflow,
    output mcu_bus_clock,
    output mcu_bus,
    output mcu_bus_command_data
  );
endinterface

// File: rtl/mcu_bus_transmitter.sv
// Queues tagged bytes and serializes them onto the 8-bit MCU bus,
// one byte per generated bus clock, sampled by the receiver on its rise.
module mcu_bus_transmitter #(
  parameter int CLOCK_DIVIDER = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input logic                  system_clock,
  input logic                  reset_n,
  mcu_bus_transmitter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW =
    (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLOCK_DIVIDER - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [8:0]    out_q, out_d;
  logic          clk_q, clk_d;
  logic          ovf_q, ovf_d;
  logic [8:0]    mem_q [FIFO_DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Extra pointer MSB tells a full queue from an empty one
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push  = bus.write_enable && !full;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          pop     = !empty;
          state_d = empty ? IDLE : SETUP;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_d  = push ? (wr_q + PTR_ONE) : wr_q;
    rd_d  = pop ? (rd_q + PTR_ONE) : rd_q;
    out_d = pop ? mem_q[rd_q[AW-1:0]] : out_q;
    clk_d = (state_d == STROBE);
    ovf_d = ovf_q | (bus.write_enable & full);
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      out_q   <= '0;
      clk_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      out_q   <= out_d;
      clk_q   <= clk_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only read behind the pointers
  always_ff @(posedge system_clock) begin
    if (push) begin
      mem_q[wr_q[AW-1:0]] <= {bus.write_is_data, bus.write_byte};
    end
  end

  assign bus.fifo_full            = full;
  assign bus.fifo_empty           = empty;
  assign bus.busy                 = (state_q != IDLE);
  assign bus.overflow             = ovf_q;
  assign bus.mcu_bus_clock        = clk_q;
  assign bus.mcu_bus              = out_q[7:0];
  assign bus.mcu_bus_command_data = out_q[8];
endmodule
